// File: rtl/rank_classifier.sv
// rank_classifier: gathers one mismatch score per rank kernel, scans them serially for the
// minimum and emits a rank decision or a reject. Define RANK_MARGIN_EN for best/second-best margin rejection.
module rank_classifier #(
    parameter int NUM_RANKS        = 13,
    parameter int SCORE_WIDTH      = 11,
    parameter int REJECT_THRESHOLD = 400
`ifdef RANK_MARGIN_EN
    ,
    parameter int MIN_MARGIN       = 40
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic [NUM_RANKS*SCORE_WIDTH-1:0] score_in,
    input  logic [NUM_RANKS-1:0]             score_valid,
    output logic [3:0]                       rank_out,
    output logic [SCORE_WIDTH-1:0]           best_score,
    output logic                             rank_valid,
    output logic                             rank_reject,
    output logic                             busy,
    output logic                             overrun
`ifdef RANK_MARGIN_EN
    ,
    output logic [SCORE_WIDTH-1:0]           margin
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0]             LAST_IDX = 4'(NUM_RANKS - 1);
    localparam logic [3:0]             NO_RANK  = 4'hF;
    localparam logic [SCORE_WIDTH-1:0] THRESH   = SCORE_WIDTH'(REJECT_THRESHOLD);
`ifdef RANK_MARGIN_EN
    localparam logic [SCORE_WIDTH-1:0] MIN_M    = SCORE_WIDTH'(MIN_MARGIN);
`endif

    state_t                 state_q;
    logic [NUM_RANKS-1:0]   pending_q;
    logic [NUM_RANKS-1:0]   pending_d;
    logic [SCORE_WIDTH-1:0] score_q [NUM_RANKS];
    logic [3:0]             idx_q;
    logic [SCORE_WIDTH-1:0] best_q;
    logic [3:0]             best_idx_q;
    logic [SCORE_WIDTH-1:0] cur_score;
    logic                   cur_lt_best;
    logic                   reject_d;

    logic [3:0]             rank_out_q;
    logic [SCORE_WIDTH-1:0] best_score_q;
    logic                   rank_valid_q;
    logic                   rank_reject_q;
    logic                   overrun_q;

`ifdef RANK_MARGIN_EN
    logic [SCORE_WIDTH-1:0] second_q;
    logic [SCORE_WIDTH-1:0] margin_q;
    logic [SCORE_WIDTH-1:0] margin_d;
    logic                   cur_lt_second;
`endif

    always_comb begin
        // frame_start clears first so a score arriving in the same cycle still counts
        pending_d   = frame_start ? '0 : pending_q;
        pending_d   = pending_d | score_valid;
        cur_score   = score_q[idx_q];
        cur_lt_best = (cur_score < best_q);
        reject_d    = (best_q > THRESH);
`ifdef RANK_MARGIN_EN
        cur_lt_second = (cur_score < second_q);
        margin_d      = second_q - best_q;
        reject_d      = reject_d | (margin_d < MIN_M);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            pending_q     <= '0;
            for (int i = 0; i < NUM_RANKS; i++) begin
                score_q[i] <= '0;
            end
            idx_q         <= '0;
            best_q        <= '1;
            best_idx_q    <= NO_RANK;
            rank_out_q    <= NO_RANK;
            best_score_q  <= '0;
            rank_valid_q  <= 1'b0;
            rank_reject_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef RANK_MARGIN_EN
            second_q      <= '1;
            margin_q      <= '0;
`endif
        end else begin
            rank_valid_q <= 1'b0;
            overrun_q    <= (state_q != COLLECT) && (|score_valid);
            case (state_q)
                COLLECT: begin
                    pending_q <= pending_d;
                    for (int i = 0; i < NUM_RANKS; i++) begin
                        if (score_valid[i]) begin
                            score_q[i] <= score_in[i*SCORE_WIDTH +: SCORE_WIDTH];
                        end
                    end
                    if (&pending_d) begin
                        state_q    <= SCAN;
                        idx_q      <= '0;
                        best_q     <= '1;
                        best_idx_q <= NO_RANK;
`ifdef RANK_MARGIN_EN
                        second_q   <= '1;
`endif
                    end
                end
                SCAN: begin
                    if (frame_start) begin
                        state_q   <= COLLECT;
                        pending_q <= '0;
                    end else begin
                        // strict compare keeps the lower index on ties
                        if (cur_lt_best) begin
                            best_q     <= cur_score;
                            best_idx_q <= idx_q;
`ifdef RANK_MARGIN_EN
                            second_q   <= best_q;
                        end else if (cur_lt_second) begin
                            second_q   <= cur_score;
`endif
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    rank_valid_q  <= 1'b1;
                    rank_reject_q <= reject_d;
                    rank_out_q    <= reject_d ? NO_RANK : best_idx_q;
                    best_score_q  <= best_q;
`ifdef RANK_MARGIN_EN
                    margin_q      <= margin_d;
`endif
                    pending_q     <= '0;
                    state_q       <= COLLECT;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign rank_out    = rank_out_q;
    assign best_score  = best_score_q;
    assign rank_valid  = rank_valid_q;
    assign rank_reject = rank_reject_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != COLLECT);
`ifdef RANK_MARGIN_EN
    assign margin      = margin_q;
`endif

endmodule

// File: tb/tb_rank_classifier.sv
// Testbench for rank_classifier: directed and random score frames checked against a
// sorted-list reference model through an expected-result queue.
module tb_rank_classifier;

    localparam int NR  = 13;
    localparam int SW  = 11;
    localparam int THR = 400;
`ifdef RANK_MARGIN_EN
    localparam int MINM = 40;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [NR*SW-1:0]  score_in = '0;
    logic [NR-1:0]     score_valid = '0;
    logic [3:0]        rank_out;
    logic [SW-1:0]     best_score;
    logic              rank_valid;
    logic              rank_reject;
    logic              busy;
    logic              overrun;
`ifdef RANK_MARGIN_EN
    logic [SW-1:0]     margin;
`endif

    always #5 clk = ~clk;

    rank_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .score_in    (score_in),
        .score_valid (score_valid),
        .rank_out    (rank_out),
        .best_score  (best_score),
        .rank_valid  (rank_valid),
        .rank_reject (rank_reject),
        .busy        (busy),
        .overrun     (overrun)
`ifdef RANK_MARGIN_EN
        ,
        .margin      (margin)
`endif
    );

    typedef struct {
        int rank;
        int score;
        int reject;
        int marg;
        int cyc;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   valid_count = 0;
    int   overrun_count = 0;
    int   busy_until = 0;
    int   last_k = 0;
    bit   m_done;
    int   m_scores[NR];
    bit   m_pending[NR];
    int   vec[NR];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sort the stored scores; the minimum is the head, margin is head gap,
    // winner is the lowest rank index holding the minimum.
    function automatic res_t model_result();
        int   s[$];
        res_t r;
        for (int i = 0; i < NR; i++) s.push_back(m_scores[i]);
        s.sort();
        r.score  = s[0];
        r.marg   = s[1] - s[0];
        r.rank   = 15;
        for (int i = NR - 1; i >= 0; i--) if (m_scores[i] == s[0]) r.rank = i;
        r.reject = (s[0] > THR) ? 1 : 0;
`ifdef RANK_MARGIN_EN
        if (r.marg < MINM) r.reject = 1;
`endif
        if (r.reject == 1) r.rank = 15;
        r.cyc = cyc + NR + 2;
        return r;
    endfunction

    function automatic void model_cycle(input logic [NR-1:0] v, input bit fs);
        bit all;
        m_done = 0;
        if (fs) for (int i = 0; i < NR; i++) m_pending[i] = 0;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) begin
                m_scores[i]  = int'(score_in[i*SW +: SW]);
                m_pending[i] = 1;
            end
        end
        all = 1;
        for (int i = 0; i < NR; i++) if (!m_pending[i]) all = 0;
        if (all) begin
            exp_q.push_back(model_result());
            for (int i = 0; i < NR; i++) m_pending[i] = 0;
            busy_until = cyc + NR + 2;
            last_k     = cyc;
            m_done     = 1;
        end
    endfunction

    task automatic set_score(input int i, input int s);
        score_in[i*SW +: SW] = SW'(s);
    endtask

    // Drives one COLLECT cycle; called and returns at a negedge.
    task automatic drive(input logic [NR-1:0] v, input bit fs);
        while (cyc < busy_until) @(negedge clk);
        score_valid = v;
        frame_start = fs;
        model_cycle(v, fs);
        @(negedge clk);
        score_valid = '0;
        frame_start = 1'b0;
    endtask

    task automatic send_vec();
        for (int i = 0; i < NR; i++) set_score(i, vec[i]);
        drive('1, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (overrun) overrun_count++;
        if (rank_valid) begin
            valid_count++;
            check("rank_valid_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rank_out", int'(rank_out), mon_e.rank);
                check("best_score", int'(best_score), mon_e.score);
                check("rank_reject", int'(rank_reject), mon_e.reject);
                check("latency_cycle", cyc, mon_e.cyc);
`ifdef RANK_MARGIN_EN
                check("margin", int'(margin), mon_e.marg);
`endif
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rank_out"}, int'(rank_out), 15);
        check({tag, "_best_score"}, int'(best_score), 0);
        check({tag, "_rank_valid"}, int'(rank_valid), 0);
        check({tag, "_rank_reject"}, int'(rank_reject), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int vc0;
        int ov0;
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) begin
            m_scores[i]  = 0;
            m_pending[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Descending scores with rank 11 a clear winner
        for (int i = 0; i < NR; i++) vec[i] = 500 - 20 * i;
        vec[11] = 50;
        send_vec();
        check("busy_after_last_score", int'(busy), 1);
        wait_drain(40);

        // All 450: above threshold
        for (int i = 0; i < NR; i++) vec[i] = 450;
        send_vec();
        wait_drain(40);

        // Tie between ranks 3 and 7
        for (int i = 0; i < NR; i++) vec[i] = 900;
        vec[3] = 100;
        vec[7] = 100;
        send_vec();
        wait_drain(40);

        // Threshold boundary: 400 accepted, 401 rejected
        for (int i = 0; i < NR; i++) vec[i] = 2047;
        vec[9] = 400;
        send_vec();
        wait_drain(40);
        for (int i = 0; i < NR; i++) vec[i] = 2047;
        vec[0] = 401;
        send_vec();
        wait_drain(40);

        // Margin boundary pair and extreme values
        for (int i = 0; i < NR; i++) vec[i] = 1000;
        vec[2] = 100;
        vec[6] = 139;
        send_vec();
        wait_drain(40);
        vec[6] = 140;
        send_vec();
        wait_drain(40);
        for (int i = 0; i < NR; i++) vec[i] = 2047;
        send_vec();
        wait_drain(40);
        for (int i = 0; i < NR; i++) vec[i] = 0;
        send_vec();
        wait_drain(40);

        // Staggered arrival, rank 5 overwritten 300 -> 120
        vc0 = valid_count;
        for (int i = 0; i < NR; i++) begin
            set_score(i, (i == 5) ? 300 : 200);
            drive(NR'(1) << i, 1'b0);
            if (i == 5) begin
                set_score(5, 120);
                drive(NR'(1) << 5, 1'b0);
            end
        end
        wait_drain(40);
        repeat (5) @(negedge clk);
        check("staggered_valid_count", valid_count - vc0, 1);

        // Abort on SCAN idx 4
        for (int i = 0; i < NR; i++) vec[i] = 300 + i;
        send_vec();
        vc0 = valid_count;
        while (cyc < last_k + 5) @(negedge clk);
        check("busy_before_abort", int'(busy), 1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("busy_after_abort", int'(busy), 0);
        void'(exp_q.pop_back());
        busy_until = cyc;
        repeat (20) @(negedge clk);
        check("abort_valid_count", valid_count - vc0, 0);
        for (int i = 0; i < NR; i++) vec[i] = 600 - 7 * i;
        send_vec();
        wait_drain(40);

        // score_valid during SCAN
        for (int i = 0; i < NR; i++) vec[i] = 250 + 3 * i;
        vec[8] = 60;
        send_vec();
        ov0 = overrun_count;
        while (cyc < last_k + 5) @(negedge clk);
        set_score(2, 0);
        score_valid = NR'(1) << 2;
        @(negedge clk);
        score_valid = '0;
        check("overrun_pulse", int'(overrun), 1);
        wait_drain(40);
        check("overrun_count", overrun_count - ov0, 1);

        // Reset in the middle of SCAN
        for (int i = 0; i < NR; i++) vec[i] = 700 - 11 * i;
        send_vec();
        vc0 = valid_count;
        while (cyc < last_k + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midscan_reset");
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            m_scores[i]  = 0;
            m_pending[i] = 0;
        end
        busy_until = cyc;
        repeat (20) @(negedge clk);
        check("reset_valid_count", valid_count - vc0, 0);

        // Random frames: sparse/dense arrivals, repeats, occasional frame_start
        for (int f = 0; f < 30; f++) begin
            int n = 0;
            m_done = 0;
            while (!m_done && n < 300) begin
                case ($urandom_range(0, 3))
                    0: v = '0;
                    1: v = NR'($urandom);
                    default: v = NR'(1) << $urandom_range(0, NR - 1);
                endcase
                if ($urandom_range(0, 19) == 0) v = '1;
                for (int i = 0; i < NR; i++) begin
                    if ($urandom_range(0, 1) == 0) set_score(i, $urandom_range(0, 2047));
                    else set_score(i, $urandom_range(360, 440));
                end
                drive(v, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
                n++;
            end
            wait_drain(40);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
